// File: rtl/saradc_pkg.sv
// rtl/saradc_pkg.sv - shared state encoding and default parameters for the SAR sequencer
package saradc_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SAMPLE  = 3'd1,
      SETTLE  = 3'd2,
      COMPARE = 3'd3,
      DECIDE  = 3'd4,
      DONE    = 3'd5
   } sar_state_t;

   localparam int DEF_NBITS         = 8;
   localparam int DEF_SAMPLE_CYCLES = 2;
   localparam int DEF_SETTLE_CYCLES = 1;

endpackage

// File: rtl/saradc_sar_ctrl_if.sv
// rtl/saradc_sar_ctrl_if.sv - host/analog-side signal bundle of the SAR sequencer
interface saradc_sar_ctrl_if #(
   parameter int NBITS = saradc_pkg::DEF_NBITS
);
   logic             START;
   logic             ABORT;
   logic             CMP_OUT;
   logic             SAMPLE;
   logic             CMP_EN;
   logic [NBITS-1:0] DAC;
   logic             BUSY;
   logic             DONE;
   logic [NBITS-1:0] DOUT;

   modport master (
      output START, ABORT, CMP_OUT,
      input  SAMPLE, CMP_EN, DAC, BUSY, DONE, DOUT
   );

   modport slave (
      input  START, ABORT, CMP_OUT,
      output SAMPLE, CMP_EN, DAC, BUSY, DONE, DOUT
   );
endinterface

// File: rtl/saradc_dly_cnt.sv
// rtl/saradc_dly_cnt.sv - loadable down-counter that stops at zero and flags it
module saradc_dly_cnt #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);
   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);
endmodule

// File: rtl/saradc_sar_ctrl.sv
// rtl/saradc_sar_ctrl.sv - successive-approximation sequencer: sample, trial, strobe, resolve
module saradc_sar_ctrl
   import saradc_pkg::*;
#(
   parameter int NBITS         = DEF_NBITS,
   parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input logic               CLK,
   input logic               RST_N,
   saradc_sar_ctrl_if.slave  bus
);
   localparam int CMAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int IW   = $clog2(NBITS);

   localparam logic [CW-1:0]    SAMPLE_LOAD = CW'(SAMPLE_CYCLES - 1);
   localparam logic [CW-1:0]    SETTLE_LOAD = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam sar_state_t       TRIAL_ST    = (SETTLE_CYCLES > 0) ? SETTLE : COMPARE;
   localparam logic [NBITS-1:0] ONE         = NBITS'(1);
   localparam logic [NBITS-1:0] TOP_BIT     = ONE << (NBITS - 1);

   sar_state_t       state, nxt;
   logic [NBITS-1:0] result, res_n, dac, dout;
   logic [IW-1:0]    idx;
   logic             cnt_load, cnt_zero;
   logic [CW-1:0]    cnt_val;
   logic             sample_q, cmp_en_q, busy_q, done_q;

   saradc_dly_cnt #(.W(CW)) u_dly (
      .clk      (CLK),
      .resetn   (RST_N),
      .load     (cnt_load),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   always_comb begin
      res_n      = result;
      res_n[idx] = bus.CMP_OUT;
   end

   always_comb begin
      nxt      = state;
      cnt_load = 1'b0;
      cnt_val  = SETTLE_LOAD;
      if (state != IDLE && bus.ABORT) begin
         nxt = IDLE;
      end else begin
         case (state)
            IDLE: if (bus.START) begin
               nxt      = SAMPLE;
               cnt_load = 1'b1;
               cnt_val  = SAMPLE_LOAD;
            end
            SAMPLE: if (cnt_zero) begin
               nxt      = TRIAL_ST;
               cnt_load = 1'b1;
            end
            SETTLE:  if (cnt_zero) nxt = COMPARE;
            COMPARE: nxt = DECIDE;
            DECIDE: begin
               if (idx == '0) begin
                  nxt = DONE;
               end else begin
                  nxt      = TRIAL_ST;
                  cnt_load = 1'b1;
               end
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
         endcase
      end
   end

   // Strobes are registered from the next state so they line up with the state they describe.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state    <= IDLE;
         result   <= '0;
         idx      <= '0;
         dac      <= '0;
         dout     <= '0;
         sample_q <= 1'b0;
         cmp_en_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= nxt;
         sample_q <= (nxt == SAMPLE);
         cmp_en_q <= (nxt == COMPARE);
         busy_q   <= (nxt != IDLE);
         done_q   <= (nxt == DONE);
         if (nxt == IDLE) dac <= '0;
         case (state)
            IDLE: if (nxt == SAMPLE) begin
               result <= '0;
               dac    <= '0;
            end
            SAMPLE: if (nxt != IDLE && cnt_zero) begin
               idx <= IW'(NBITS - 1);
               dac <= result | TOP_BIT;
            end
            DECIDE: if (nxt != IDLE) begin
               result <= res_n;
               if (idx == '0) begin
                  dac  <= '0;
                  dout <= res_n;
               end else begin
                  idx <= idx - IW'(1);
                  dac <= res_n | (ONE << (idx - IW'(1)));
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.SAMPLE = sample_q;
   assign bus.CMP_EN = cmp_en_q;
   assign bus.DAC    = dac;
   assign bus.BUSY   = busy_q;
   assign bus.DONE   = done_q;
   assign bus.DOUT   = dout;
endmodule

// File: tb/tb_saradc_sar_ctrl.sv
// tb/tb_saradc_sar_ctrl.sv - randomized self-checking bench for saradc_sar_ctrl
module tb_saradc_sar_ctrl;
   localparam int NB    = 8;
   localparam int SMP   = 2;
   localparam int TA    = 1;
   localparam int TB    = 0;
   localparam int LAT_A = SMP + NB * (TA + 2);
   localparam int LAT_B = SMP + NB * (TB + 2);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [NB-1:0] vin_d = '0;
   logic [NB-1:0] last_dout = '0;
   int            n_checks = 0;
   int            n_errors = 0;

   always #5 clk = ~clk;

   saradc_sar_ctrl_if #(.NBITS(NB)) ia ();
   saradc_sar_ctrl_if #(.NBITS(NB)) ib ();

   assign ia.START   = start;
   assign ia.ABORT   = abort;
   assign ia.CMP_OUT = (vin_d >= ia.DAC);
   assign ib.START   = start;
   assign ib.ABORT   = abort;
   assign ib.CMP_OUT = (vin_d >= ib.DAC);

   saradc_sar_ctrl #(.NBITS(NB), .SAMPLE_CYCLES(SMP), .SETTLE_CYCLES(TA)) dut_a (
      .CLK(clk), .RST_N(rst_n), .bus(ia));
   saradc_sar_ctrl #(.NBITS(NB), .SAMPLE_CYCLES(SMP), .SETTLE_CYCLES(TB)) dut_b (
      .CLK(clk), .RST_N(rst_n), .bus(ib));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_quiet(input string tag, input logic [NB-1:0] exp_dout);
      chk({tag, "_sample_a"}, ia.SAMPLE, 0);
      chk({tag, "_cmpen_a"},  ia.CMP_EN, 0);
      chk({tag, "_dac_a"},    ia.DAC,    0);
      chk({tag, "_busy_a"},   ia.BUSY,   0);
      chk({tag, "_done_a"},   ia.DONE,   0);
      chk({tag, "_dout_a"},   ia.DOUT,   exp_dout);
      chk({tag, "_sample_b"}, ib.SAMPLE, 0);
      chk({tag, "_cmpen_b"},  ib.CMP_EN, 0);
      chk({tag, "_dac_b"},    ib.DAC,    0);
      chk({tag, "_busy_b"},   ib.BUSY,   0);
      chk({tag, "_done_b"},   ib.DONE,   0);
      chk({tag, "_dout_b"},   ib.DOUT,   exp_dout);
   endtask

   // Reference: plain binary search of the input code, one trial level per resolved bit.
   task automatic conv(input logic [NB-1:0] vin);
      logic [NB-1:0] tr[NB];
      logic [NB-1:0] r;
      int ce_a = 0, ce_b = 0, sa_a = 0, sa_b = 0, dn_a = 0, dn_b = 0, dc_a = -1, dc_b = -1;
      r = '0;
      for (int b = NB - 1; b >= 0; b--) begin
         tr[NB-1-b] = r | (NB'(1) << b);
         if (vin >= tr[NB-1-b]) r = tr[NB-1-b];
      end
      @(negedge clk);
      vin_d = vin;
      start = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= LAT_A + 2; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (ia.CMP_EN) begin
            if (ce_a < NB) begin
               chk("trial_a", ia.DAC, tr[ce_a]);
               chk("cmpen_pos_a", c, SMP + ce_a * (TA + 2) + TA + 1);
            end
            ce_a++;
         end
         if (ib.CMP_EN) begin
            if (ce_b < NB) begin
               chk("trial_b", ib.DAC, tr[ce_b]);
               chk("cmpen_pos_b", c, SMP + ce_b * (TB + 2) + TB + 1);
            end
            ce_b++;
         end
         if (ia.SAMPLE) sa_a++;
         if (ib.SAMPLE) sa_b++;
         if (ia.DONE) begin dn_a++; dc_a = c; chk("dout_a", ia.DOUT, vin); end
         if (ib.DONE) begin dn_b++; dc_b = c; chk("dout_b", ib.DOUT, vin); end
         if (c == LAT_B + 2) chk("busy_after_b", ib.BUSY, 0);
      end
      chk("busy_after_a", ia.BUSY, 0);
      chk("cmpen_cnt_a", ce_a, NB);
      chk("cmpen_cnt_b", ce_b, NB);
      chk("sample_cnt_a", sa_a, SMP);
      chk("sample_cnt_b", sa_b, SMP);
      chk("done_cnt_a", dn_a, 1);
      chk("done_cnt_b", dn_b, 1);
      chk("done_cyc_a", dc_a, LAT_A + 1);
      chk("done_cyc_b", dc_b, LAT_B + 1);
      chk("hold_dout_a", ia.DOUT, vin);
      last_dout = vin;
   endtask

   task automatic abort_test(input logic [NB-1:0] vin);
      int dn = 0;
      @(negedge clk);
      vin_d = vin;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("abort_busy_before", ia.BUSY, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk_quiet("abort", last_dout);
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (ia.DONE || ib.DONE) dn++;
      end
      chk("abort_no_done", dn, 0);
      chk("abort_dout_kept", ia.DOUT, last_dout);
   endtask

   task automatic b2b_test(input logic [NB-1:0] vin);
      int ta[$];
      int tb[$];
      @(negedge clk);
      vin_d = vin;
      start = 1'b1;
      for (int c = 0; c < 130; c++) begin
         @(negedge clk);
         if (ia.DONE) begin ta.push_back(c); chk("b2b_dout_a", ia.DOUT, vin); end
         if (ib.DONE) begin tb.push_back(c); chk("b2b_dout_b", ib.DOUT, vin); end
      end
      start = 1'b0;
      repeat (40) @(negedge clk);
      chk("b2b_cnt_a", ta.size(), 4);
      chk("b2b_cnt_b", tb.size(), 6);
      for (int i = 1; i < ta.size(); i++) chk("b2b_gap_a", ta[i] - ta[i-1], LAT_A + 2);
      for (int i = 1; i < tb.size(); i++) chk("b2b_gap_b", tb[i] - tb[i-1], LAT_B + 2);
      last_dout = vin;
   endtask

   task automatic reset_mid_test(input logic [NB-1:0] vin);
      @(negedge clk);
      vin_d = vin;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      chk("rst_busy_before", ia.BUSY, 1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk_quiet("rst_mid", '0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk_quiet("reset", '0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      conv(8'hA5);
      conv(8'h00);
      conv(8'hFF);
      for (int i = 0; i < 6; i++) conv(NB'($urandom_range(0, 255)));
      conv(8'hA5);
      abort_test(NB'($urandom_range(0, 255)));
      b2b_test(8'h3C);
      reset_mid_test(8'h5A);
      conv(8'h5A);
      conv(NB'($urandom_range(0, 255)));
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/saradc_sar_ctrl.md
Name: saradc_sar_ctrl

Overview:
Synchronous successive-approximation sequencer for the SAR ADC. It drives the sampling switch, steps the capacitive-DAC trial code MSB-first and strobes the latched comparator. It then resolves each bit from the comparator decision and presents the result with a one-cycle done pulse. It sits between the digital host and the SARADC_CELL-based switch drivers and comparator.

Parameters:
NBITS, 8, conversion resolution in bits (2..16)
SAMPLE_CYCLES, 2, cycles the sampling switch stays closed (>=1)
SETTLE_CYCLES, 1, DAC settling cycles before each comparator strobe (>=0; 0 skips SETTLE)

Ports:
CLK  input  1  single clock, all logic on rising edge
RST_N  input  1  reset, synchronous, active-low
START  input  1  conversion request, sampled only in IDLE
ABORT  input  1  synchronous abort, returns to IDLE
CMP_OUT  input  1  latched comparator decision, 1 = Vin >= DAC trial level
SAMPLE  output  1  sampling switch enable
CMP_EN  output  1  comparator latch strobe
DAC  output  NBITS  trial code to DAC switch drivers
BUSY  output  1  high in every state except IDLE
DONE  output  1  one-cycle pulse, DOUT updated this cycle
DOUT  output  NBITS  last completed result, held until next completion

Behaviour:
- Clock and reset: one clock CLK; reset RST_N is synchronous and active-low.
- Reset (RST_N=0 at an edge), including mid-conversion: state=IDLE, SAMPLE=0, CMP_EN=0, DAC=0, BUSY=0, DONE=0, DOUT=0, counters=0.
- States: IDLE, SAMPLE, SETTLE, COMPARE, DECIDE, DONE.
- IDLE: if START=1, go to SAMPLE next cycle, clear the result register, DAC=0.
- SAMPLE: SAMPLE=1 for exactly SAMPLE_CYCLES cycles. On exit, bit index i=NBITS-1 and DAC=result|(1<<i). Go to SETTLE, or to COMPARE if SETTLE_CYCLES=0.
- SETTLE: hold DAC for SETTLE_CYCLES cycles, then go to COMPARE.
- COMPARE: CMP_EN=1 for one cycle, DAC held, then go to DECIDE.
- DECIDE: CMP_EN=0 and CMP_OUT is sampled at the edge ending this cycle.
  - result[i] = CMP_OUT.
  - If i>0: i=i-1, DAC = updated result | (1<<(i-1)), go to SETTLE (or COMPARE).
  - If i=0: DAC=0, go to DONE.
- DONE: one cycle. DONE=1 and DOUT=final result (registered output, valid in the same cycle as DONE), BUSY=1. Always go to IDLE next; START is ignored in this cycle.
- CMP_OUT is ignored in every state except DECIDE (X-tolerant).
- Latency: START accepted at edge k gives DONE=1 in the cycle after edge k + SAMPLE_CYCLES + NBITS*(SETTLE_CYCLES+2).
  - Default: 2 + 8*3 = 26, so DONE is high in cycle k+27.
  - Minimum conversion period with START held high is that value +2 (DONE and IDLE cycles).
- START while BUSY: ignored, no queuing.
- ABORT=1 in any non-IDLE state: IDLE next cycle, all strobes 0, DAC=0, no DONE pulse, DOUT unchanged. ABORT wins over START in the same cycle. ABORT in IDLE has no effect.
- RST_N has priority over ABORT and START.
- Counters: sample/settle counter width is clog2(max(SAMPLE_CYCLES,SETTLE_CYCLES)+1); bit index width is clog2(NBITS). Neither wraps, both reload on every state entry.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Package saradc_pkg holds:
  - the state enum (sar_state_t: IDLE, SAMPLE, SETTLE, COMPARE, DECIDE, DONE);
  - the default NBITS, SAMPLE_CYCLES and SETTLE_CYCLES constants.
- Sub-module saradc_dly_cnt: loadable down-counter with zero flag, shared by the SAMPLE and SETTLE timing.
- Successive-approximation register and bit index stay in saradc_sar_ctrl.

Test Plan:
- Defaults, comparator model CMP_OUT=(0xA5>=DAC), START pulse at edge k:
  - DAC trials are 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
  - DONE is high only in cycle k+27, with DOUT=0xA5.
  - CMP_EN has exactly 8 single-cycle pulses and SAMPLE is high for 2 cycles.
- Input codes 0x00 and 0xFF: DOUT=0x00 and 0xFF respectively. Final-bit DAC trials are 0x01 and 0xFF. BUSY drops the cycle after DONE.
- ABORT asserted 10 cycles after START, previous DOUT=0xA5: IDLE next cycle, no DONE pulse, DOUT stays 0xA5, DAC=0, SAMPLE=0, CMP_EN=0.
- START held high with input 0x3C: back-to-back conversions with DONE pulses exactly 28 cycles apart, DOUT=0x3C each time. START pulses during BUSY do not shorten or restart a conversion.
- SETTLE_CYCLES=0, input 0x5A: DONE in cycle k+19, DOUT=0x5A. CMP_EN is asserted the cycle after each DAC update.
- RST_N=0 for one edge mid-conversion (cycle k+12): all outputs go to 0 at that edge, including DOUT. A new START then converts normally.
